// File: rtl/spi_master_arbiter_pkg.sv
// Shared types and helpers for the SPI master arbiter.
package spi_arb_pkg;

   // Transaction phases of the arbiter FSM
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CONFIG = 3'd1,
      SEND   = 3'd2,
      WAIT   = 3'd3,
      RESP   = 3'd4
   } state_t;

   // Packet size actually programmed into the master: 0 or oversize means full width
   function automatic int unsigned eff_psize(input int unsigned psize, input int unsigned nbits);
      return ((psize == 0) || (psize > nbits)) ? nbits : psize;
   endfunction

endpackage

// File: rtl/spi_master_arbiter_if.sv
// Bus bundle between SoC requesters, the arbiter and the shared spi_master.
// modport master: the arbiter side; modport slave: the environment side.
interface spi_master_arbiter_if #(
   parameter int nreqs      = 4,
   parameter int nbits      = 32,
   parameter int psize_bits = $clog2(nbits) + 1
);
   localparam int IW = $clog2(nreqs);

   logic [nreqs-1:0]                    req_val;
   logic [nreqs-1:0]                    req_rdy;
   logic [nreqs*(psize_bits+nbits)-1:0] req_msg;
   logic [nreqs-1:0]                    resp_val;
   logic [nreqs-1:0]                    resp_rdy;
   logic [nbits-1:0]                    resp_msg;

   logic                                spi_cs_addr_val;
   logic [IW-1:0]                       spi_cs_addr_msg;
   logic                                spi_packet_size_val;
   logic [psize_bits-1:0]               spi_packet_size_msg;
   logic                                spi_req_val;
   logic                                spi_req_rdy;
   logic [nbits-1:0]                    spi_req_msg;
   logic                                spi_resp_val;
   logic                                spi_resp_rdy;
   logic [nbits-1:0]                    spi_resp_msg;

   modport master (
      input  req_val, req_msg, resp_rdy, spi_req_rdy, spi_resp_val, spi_resp_msg,
      output req_rdy, resp_val, resp_msg, spi_cs_addr_val, spi_cs_addr_msg,
             spi_packet_size_val, spi_packet_size_msg, spi_req_val, spi_req_msg,
             spi_resp_rdy
   );

   modport slave (
      output req_val, req_msg, resp_rdy, spi_req_rdy, spi_resp_val, spi_resp_msg,
      input  req_rdy, resp_val, resp_msg, spi_cs_addr_val, spi_cs_addr_msg,
             spi_packet_size_val, spi_packet_size_msg, spi_req_val, spi_req_msg,
             spi_resp_rdy
   );

endinterface

// File: rtl/spi_master_arbiter_rr.sv
// Combinational round-robin picker: lowest requesting index at or after ptr, cyclically.
module rr_arbiter #(
   parameter int nreqs = 4
) (
   input  logic [nreqs-1:0]         reqs,
   input  logic [$clog2(nreqs)-1:0] ptr,
   output logic [nreqs-1:0]         grant_onehot,
   output logic [$clog2(nreqs)-1:0] grant_idx,
   output logic                     any
);
   localparam int IW = $clog2(nreqs);

   logic [IW-1:0] idx;

   // Scan from the farthest offset down so the nearest requester after ptr wins
   always_comb begin
      idx       = '0;
      grant_idx = '0;
      any       = 1'b0;
      for (int k = nreqs - 1; k >= 0; k--) begin
         idx = IW'((int'(ptr) + k) % nreqs);
         if (reqs[idx]) begin
            grant_idx = idx;
            any       = 1'b1;
         end
      end
      grant_onehot = '0;
      if (any) grant_onehot[grant_idx] = 1'b1;
   end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one spi_master among nreqs requesters, one transaction at a time,
// with round-robin grant advanced only on completed transactions.
module spi_master_arbiter
   import spi_arb_pkg::*;
#(
   parameter int nreqs      = 4,
   parameter int nbits      = 32,
   parameter int psize_bits = $clog2(nbits) + 1
) (
   input logic                  clk,
   input logic                  reset,
   spi_master_arbiter_if.master bus
);
   localparam int IW = $clog2(nreqs);
   localparam int MW = psize_bits + nbits;

   state_t                state_q;
   logic [IW-1:0]         ptr_q;
   logic [IW-1:0]         grant_q;
   logic                  cs_addr_val_q;
   logic                  psize_val_q;
   logic [psize_bits-1:0] psize_q;
   logic                  spi_req_val_q;
   logic [nbits-1:0]      spi_req_msg_q;
   logic                  spi_resp_rdy_q;
   logic [nreqs-1:0]      resp_val_q;
   logic [nbits-1:0]      resp_msg_q;

   logic [nreqs-1:0]      grant_onehot;
   logic [IW-1:0]         grant_idx;
   logic                  grant_any;

   logic [MW-1:0]         req_slice [nreqs];
   logic [MW-1:0]         sel_msg_d;
   logic [psize_bits-1:0] eff_psize_d;
   logic [nbits-1:0]      resp_mask_d;
   logic [IW-1:0]         ptr_d;
   logic [nreqs-1:0]      resp_onehot_d;

   rr_arbiter #(.nreqs(nreqs)) u_rr (
      .reqs         (bus.req_val),
      .ptr          (ptr_q),
      .grant_onehot (grant_onehot),
      .grant_idx    (grant_idx),
      .any          (grant_any)
   );

   // Unflatten request messages and pick the granted one
   always_comb begin
      for (int i = 0; i < nreqs; i++) begin
         req_slice[i] = bus.req_msg[i*MW +: MW];
      end
      sel_msg_d   = req_slice[grant_idx];
      eff_psize_d = psize_bits'(eff_psize(32'(sel_msg_d[MW-1:nbits]), nbits));
   end

   // Response mask built bitwise so a full-width packet never shifts past nbits
   always_comb begin
      resp_mask_d = '0;
      for (int i = 0; i < nbits; i++) begin
         resp_mask_d[i] = (i < int'(psize_q));
      end
      ptr_d         = (grant_q == IW'(nreqs - 1)) ? '0 : grant_q + 1'b1;
      resp_onehot_d = nreqs'(1) << grant_q;
   end

   // Transaction FSM with registered master-side and response outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         ptr_q          <= '0;
         grant_q        <= '0;
         cs_addr_val_q  <= 1'b0;
         psize_val_q    <= 1'b0;
         psize_q        <= '0;
         spi_req_val_q  <= 1'b0;
         spi_req_msg_q  <= '0;
         spi_resp_rdy_q <= 1'b0;
         resp_val_q     <= '0;
         resp_msg_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_any) begin
                  grant_q       <= grant_idx;
                  psize_q       <= eff_psize_d;
                  spi_req_msg_q <= sel_msg_d[nbits-1:0];
                  cs_addr_val_q <= 1'b1;
                  psize_val_q   <= 1'b1;
                  state_q       <= CONFIG;
               end
            end
            CONFIG: begin
               cs_addr_val_q <= 1'b0;
               psize_val_q   <= 1'b0;
               spi_req_val_q <= 1'b1;
               state_q       <= SEND;
            end
            SEND: begin
               if (bus.spi_req_rdy) begin
                  spi_req_val_q  <= 1'b0;
                  spi_resp_rdy_q <= 1'b1;
                  state_q        <= WAIT;
               end
            end
            WAIT: begin
               if (bus.spi_resp_val) begin
                  spi_resp_rdy_q <= 1'b0;
                  resp_msg_q     <= bus.spi_resp_msg & resp_mask_d;
                  resp_val_q     <= resp_onehot_d;
                  state_q        <= RESP;
               end
            end
            RESP: begin
               if (bus.resp_rdy[grant_q]) begin
                  resp_val_q <= '0;
                  ptr_q      <= ptr_d;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_rdy             = (state_q == IDLE) ? grant_onehot : '0;
   assign bus.resp_val            = resp_val_q;
   assign bus.resp_msg            = resp_msg_q;
   assign bus.spi_cs_addr_val     = cs_addr_val_q;
   assign bus.spi_cs_addr_msg     = grant_q;
   assign bus.spi_packet_size_val = psize_val_q;
   assign bus.spi_packet_size_msg = psize_q;
   assign bus.spi_req_val         = spi_req_val_q;
   assign bus.spi_req_msg         = spi_req_msg_q;
   assign bus.spi_resp_rdy        = spi_resp_rdy_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Randomized bench for spi_master_arbiter with a transaction-level reference model.
module tb_spi_master_arbiter;
   localparam int NR = 4;
   localparam int NB = 32;
   localparam int PB = 6;
   localparam int MW = PB + NB;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   spi_master_arbiter_if #(.nreqs(NR), .nbits(NB), .psize_bits(PB)) bus();

   spi_master_arbiter #(.nreqs(NR), .nbits(NB), .psize_bits(PB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int model_ptr = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference: first requester at or after the pointer, cyclically
   function automatic int model_grant(input logic [3:0] m);
      for (int k = 0; k < NR; k++) begin
         if (m[(model_ptr + k) % NR]) return (model_ptr + k) % NR;
      end
      return -1;
   endfunction

   function automatic int model_eff(input int ps);
      return (ps == 0 || ps > NB) ? NB : ps;
   endfunction

   function automatic logic [31:0] model_resp(input logic [31:0] miso, input int eff);
      longint unsigned m;
      m = (64'd1 << eff) - 64'd1;
      return miso & m[31:0];
   endfunction

   task automatic chk_quiet(input string tag);
      chk({tag, "_req_rdy"}, bus.req_rdy, 0);
      chk({tag, "_resp_val"}, bus.resp_val, 0);
      chk({tag, "_resp_msg"}, bus.resp_msg, 0);
      chk({tag, "_cs_val"}, bus.spi_cs_addr_val, 0);
      chk({tag, "_ps_val"}, bus.spi_packet_size_val, 0);
      chk({tag, "_ps_msg"}, bus.spi_packet_size_msg, 0);
      chk({tag, "_spi_req_val"}, bus.spi_req_val, 0);
      chk({tag, "_spi_req_msg"}, bus.spi_req_msg, 0);
      chk({tag, "_spi_resp_rdy"}, bus.spi_resp_rdy, 0);
   endtask

   task automatic drive_idle;
      bus.req_val      = '0;
      bus.req_msg      = '0;
      bus.resp_rdy     = '0;
      bus.spi_req_rdy  = 1'b0;
      bus.spi_resp_val = 1'b0;
      bus.spi_resp_msg = '0;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      drive_idle();
      tick();
      tick();
      reset = 1'b0;
      model_ptr = 0;
      chk_quiet("reset");
   endtask

   // One full transaction; rnd selects random per-requester payloads and MISO data
   task automatic txn(input logic [3:0] mask, input bit rnd, input int ps_in,
                      input logic [31:0] dat_in, input logic [31:0] miso_in,
                      input int req_dly, input int resp_dly, input int miso_dly);
      int          ps [NR];
      logic [31:0] dat [NR];
      int          choices [8];
      int          g;
      int          eff;
      logic [31:0] miso;
      logic [31:0] expr;
      logic [3:0]  oh;
      choices = '{0, 1, 8, 31, 32, 33, 40, 63};
      for (int i = 0; i < NR; i++) begin
         if (rnd) begin
            ps[i]  = ($urandom_range(0, 1) == 0) ? choices[$urandom_range(0, 7)] : int'($urandom_range(0, 63));
            dat[i] = $urandom;
         end else begin
            ps[i]  = ps_in;
            dat[i] = dat_in;
         end
         bus.req_msg[i*MW +: MW] = {6'(ps[i]), dat[i]};
      end
      bus.req_val = mask;
      #1;
      g  = model_grant(mask);
      oh = 4'b0001 << g;
      chk("req_rdy_grant", bus.req_rdy, oh);
      tick();
      eff = model_eff(ps[g]);
      chk("cfg_cs_val", bus.spi_cs_addr_val, 1);
      chk("cfg_cs_msg", bus.spi_cs_addr_msg, g);
      chk("cfg_ps_val", bus.spi_packet_size_val, 1);
      chk("cfg_ps_msg", bus.spi_packet_size_msg, eff);
      chk("cfg_spi_req_val", bus.spi_req_val, 0);
      chk("cfg_req_rdy", bus.req_rdy, 0);
      tick();
      for (int c = 0; c <= req_dly; c++) begin
         chk("send_val", bus.spi_req_val, 1);
         chk("send_msg", bus.spi_req_msg, dat[g]);
         chk("send_cs_val", bus.spi_cs_addr_val, 0);
         bus.spi_req_rdy = (c == req_dly);
         tick();
      end
      bus.spi_req_rdy = 1'b0;
      if (rnd) miso = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      else     miso = miso_in;
      for (int c = 0; c <= miso_dly; c++) begin
         chk("wait_resp_rdy", bus.spi_resp_rdy, 1);
         chk("wait_req_val", bus.spi_req_val, 0);
         chk("wait_resp_val", bus.resp_val, 0);
         bus.spi_resp_val = (c == miso_dly);
         bus.spi_resp_msg = (c == miso_dly) ? miso : $urandom;
         tick();
      end
      bus.spi_resp_val = 1'b0;
      expr = model_resp(miso, eff);
      for (int c = 0; c <= resp_dly; c++) begin
         chk("resp_val", bus.resp_val, oh);
         chk("resp_msg", bus.resp_msg, expr);
         chk("resp_req_rdy", bus.req_rdy, 0);
         chk("resp_spi_rdy", bus.spi_resp_rdy, 0);
         bus.resp_rdy = (c == resp_dly) ? oh : ~oh;
         tick();
      end
      bus.resp_rdy = '0;
      bus.req_val  = '0;
      model_ptr    = (g + 1) % NR;
      chk("post_resp_val", bus.resp_val, 0);
   endtask

   initial begin
      reset = 1'b1;
      drive_idle();
      do_reset();

      // Single request with echoed MISO, then pointer must sit at 1
      txn(4'b0001, 1'b0, 8, 32'h0000_00A5, 32'hFFFF_FFA5, 0, 0, 0);
      txn(4'b1111, 1'b1, 0, '0, '0, 0, 0, 0);

      // Contention from reset: 0,1,2,3
      do_reset();
      for (int t = 0; t < 4; t++) txn(4'b1111, 1'b1, 0, '0, '0, 0, 0, 0);

      // Pointer wrap: reach pointer 3, then 3 followed by 0
      do_reset();
      txn(4'b0100, 1'b1, 0, '0, '0, 0, 0, 0);
      txn(4'b1001, 1'b1, 0, '0, '0, 0, 0, 0);
      txn(4'b1001, 1'b1, 0, '0, '0, 0, 0, 0);

      // Packet-size boundaries
      txn(4'b0001, 1'b0, 0,  32'h1234_5678, 32'hDEAD_BEEF, 0, 0, 0);
      txn(4'b0010, 1'b0, 40, 32'h8765_4321, 32'hCAFE_F00D, 0, 0, 1);
      txn(4'b0100, 1'b0, 1,  32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 0);
      txn(4'b1000, 1'b0, 31, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);

      // Backpressure on both master payload and requester response
      txn(4'b0110, 1'b1, 0, '0, '0, 5, 5, 2);

      // No requests: stays idle
      bus.req_val = '0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("idle_req_rdy", bus.req_rdy, 0);
         chk("idle_cs_val", bus.spi_cs_addr_val, 0);
      end

      // Reset while waiting for MISO aborts silently
      for (int i = 0; i < NR; i++) bus.req_msg[i*MW +: MW] = {6'd8, 32'h55};
      bus.req_val = 4'b0010;
      tick();
      bus.req_val = '0;
      tick();
      bus.spi_req_rdy = 1'b1;
      tick();
      bus.spi_req_rdy = 1'b0;
      chk("abort_in_wait", bus.spi_resp_rdy, 1);
      reset = 1'b1;
      bus.spi_resp_val = 1'b1;
      bus.spi_resp_msg = 32'hFFFF_FFFF;
      tick();
      chk_quiet("abort");
      reset = 1'b0;
      bus.spi_resp_val = 1'b0;
      model_ptr = 0;
      tick();
      chk("abort_no_resp", bus.resp_val, 0);
      txn(4'b1111, 1'b1, 0, '0, '0, 0, 0, 0);

      // Randomized traffic
      for (int t = 0; t < 40; t++) begin
         logic [3:0] m;
         m = 4'($urandom_range(1, 15));
         txn(m, 1'b1, 0, '0, '0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
- Shares one spi_master instance among nreqs requesters, each with a val/rdy request/response channel pair.
- Round-robin grant per transaction.
- Per granted transaction:
  - Configures the master: chip-select address = requester index; packet size = taken from the request.
  - Issues the payload.
  - Waits for the MISO response, masks it to packet size, returns it to the granting requester.
- Sits between SoC-side clients (e.g. several peripheral drivers) and spi_master; holds at most one transaction in flight.

Parameters:
- nreqs, 4, number of requesters (2..8); also the number of chip selects.
- nbits, 32, payload width of request and response messages.
- psize_bits, $clog2(nbits)+1, width of the packet-size field (encodes 1..nbits).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_val  in  nreqs  per-requester request valid
- req_rdy  out  nreqs  per-requester request ready
- req_msg  in  nreqs*(psize_bits+nbits)  flattened; slice i = {psize[psize_bits-1:0], data[nbits-1:0]}
- resp_val  out  nreqs  per-requester response valid
- resp_rdy  in  nreqs  per-requester response ready
- resp_msg  out  nbits  response data; shared, meaningful only for the asserted resp_val bit
- spi_cs_addr_val  out  1  load chip-select address into the master
- spi_cs_addr_msg  out  $clog2(nreqs)  chip-select index
- spi_packet_size_val  out  1  load packet size into the master
- spi_packet_size_msg  out  psize_bits  packet size
- spi_req_val  out  1  payload valid to the master
- spi_req_rdy  in  1  master ready for payload
- spi_req_msg  out  nbits  payload
- spi_resp_val  in  1  master response valid
- spi_resp_rdy  out  1  ready for master response
- spi_resp_msg  in  nbits  MISO data, right-aligned

Behaviour:
- Reset (synchronous, active-high; clk rising edge):
  - State -> IDLE; priority pointer -> 0.
  - All val/rdy outputs 0; msg outputs and registers 0.
  - Reset mid-transaction aborts it: no response is issued and the master is not notified. The system resets both blocks together.
- States: IDLE -> CONFIG -> SEND -> WAIT -> RESP -> IDLE.
- IDLE:
  - req_rdy asserted only on the grant bit: the lowest index at or after the pointer (cyclic) with req_val=1. All other req_rdy bits are 0.
  - On req_val&req_rdy: latch grant index, psize and data; go to CONFIG.
  - No request: stay in IDLE.
- CONFIG (exactly 1 cycle):
  - spi_cs_addr_val=1 with spi_cs_addr_msg=grant.
  - spi_packet_size_val=1 with spi_packet_size_msg=eff_psize.
  - eff_psize = nbits if latched psize is 0 or greater than nbits, else psize.
  - Go to SEND.
- SEND:
  - spi_req_val=1, spi_req_msg=latched data.
  - Hold until spi_req_rdy; on the handshake go to WAIT.
- WAIT:
  - spi_resp_rdy=1.
  - On spi_resp_val: latch spi_resp_msg & ((1<<eff_psize)-1). When eff_psize==nbits the mask is all ones, with no shift overflow.
  - Go to RESP.
- RESP:
  - resp_val[grant]=1, resp_msg=latched data; hold until resp_rdy[grant].
  - On the handshake: pointer <= (grant+1) mod nreqs; go to IDLE.
  - resp_rdy on other indices is ignored.
- Timing: minimum latency from request handshake to resp_val is 3 cycles (CONFIG, SEND with immediate rdy, WAIT with immediate val). A new grant cannot occur in the cycle the response handshakes; next earliest grant is the following cycle.
- Requests arriving while busy wait (req_rdy=0). req_val may drop before the grant without error.
- Pointer advances only on a completed transaction. Reset is the only abort path.

Decomposition:
- Shared package spi_arb_pkg:
  - state_t enum, 3 bits: IDLE, CONFIG, SEND, WAIT, RESP.
  - Helper function eff_psize(psize, nbits).
- One sub-module: rr_arbiter.
  - Parameter nreqs.
  - Inputs: reqs[nreqs], ptr.
  - Outputs: grant_onehot, grant_idx, any.
  - Purely combinational.
- FSM, latches and pointer register live in spi_master_arbiter.

Test Plan:
- Single request: req0 psize=8, data=0xA5, master echoes 0xFFFF_FFA5 -> CONFIG shows cs_addr=0, psize=8; spi_req_msg=0xA5; resp_val[0] with resp_msg=0x0000_00A5; pointer=1.
- Contention: req_val=4'b1111 held for 4 transactions from reset -> grants in order 0,1,2,3, each response on the matching resp_val bit only.
- Pointer wrap: pointer=3, req_val=4'b1001 -> grant 3 then 0.
- Packet-size boundaries:
  - psize=0 -> spi_packet_size_msg=32, full response unmasked.
  - psize=40 -> 32.
  - psize=1 with response 0xFFFF_FFFF -> resp_msg=0x1.
- Backpressure:
  - spi_req_rdy low 5 cycles -> spi_req_val/msg stable, stays in SEND.
  - resp_rdy[grant] low 5 cycles -> resp_val/msg stable; req_rdy stays 0.
- Reset during WAIT: assert reset -> next cycle all outputs 0, state IDLE, pointer 0, no resp_val issued.
